// File: rtl/stochastic_to_binary.sv
// Stochastic-to-binary converter: counts the ones in a 2^LEN_LOG2-bit window of the
// edge-kernel stream and presents the scaled count as a pixel on a valid/ready port.
module stochastic_to_binary #(
    parameter int LEN_LOG2 = 8,
    parameter int PIX_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             z,
    input  logic             z_valid,
    input  logic             abort,
    output logic [PIX_W-1:0] pix,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int                  SHIFT    = LEN_LOG2 - PIX_W;
    localparam logic [LEN_LOG2-1:0] BIT_LAST = '1;

    logic [1:0]          state_q, state_d;
    logic [LEN_LOG2:0]   ones_cnt_q, ones_cnt_d;
    logic [LEN_LOG2-1:0] bit_cnt_q, bit_cnt_d;
    logic [PIX_W-1:0]    pix_q, pix_d;
    logic                pix_valid_q, pix_valid_d;
    logic                busy_q, busy_d;

    logic [LEN_LOG2:0]   ones_next;
    logic [LEN_LOG2:0]   ones_scaled;
    logic [PIX_W-1:0]    pix_conv;

    always_comb begin
        ones_next   = ones_cnt_q + (LEN_LOG2+1)'(z);
        ones_scaled = ones_next >> SHIFT;
        // Only a full window of ones can overflow PIX_W bits; clamp it to all-ones.
        pix_conv    = (|ones_scaled[LEN_LOG2:PIX_W]) ? '1 : ones_scaled[PIX_W-1:0];

        state_d     = state_q;
        ones_cnt_d  = ones_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        pix_d       = pix_q;
        pix_valid_d = pix_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACCUM;
                    ones_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_ACCUM: begin
                if (z_valid) begin
                    ones_cnt_d = ones_next;
                    bit_cnt_d  = bit_cnt_q + LEN_LOG2'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d     = ST_HOLD;
                        pix_d       = pix_conv;
                        pix_valid_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (start) begin
                        state_d    = ST_ACCUM;
                        ones_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pix_valid_d = 1'b0;
            end
        endcase

        // Abort overrides everything else outside IDLE, discarding any pending result.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            ones_cnt_d  = '0;
            bit_cnt_d   = '0;
            pix_valid_d = 1'b0;
        end

        busy_d = (state_d == ST_ACCUM) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ones_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign pix       = pix_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_stochastic_to_binary.sv
// Directed bench for stochastic_to_binary: expected pixels are queued when a window is
// driven and popped when the converter presents its result.
module tb_stochastic_to_binary;

    localparam int LEN_LOG2 = 8;
    localparam int PIX_W    = 8;
    localparam int WIN      = 1 << LEN_LOG2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             z;
    logic             z_valid;
    logic             abort;
    logic [PIX_W-1:0] pix;
    logic             pix_valid;
    logic             pix_ready;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    stochastic_to_binary #(.LEN_LOG2(LEN_LOG2), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .z         (z),
        .z_valid   (z_valid),
        .abort     (abort),
        .pix       (pix),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_pix(input int ones);
        int s;
        s = ones >> (LEN_LOG2 - PIX_W);
        return (s > (1 << PIX_W) - 1) ? (1 << PIX_W) - 1 : s;
    endfunction

    // Drives bits [first, last) of a window; bit i is one if i < n_ones (or i even when alt).
    task automatic drive_bits(input int first, input int last, input int n_ones,
                              input bit alt, input bit gaps, input int start_at);
        for (int i = first; i < last; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                z = 1'b1; z_valid = 1'b0;
                step();
            end
            z       = alt ? (i % 2 == 0) : (i < n_ones);
            z_valid = 1'b1;
            start   = (i == start_at);
            step();
            start = 1'b0;
        end
        z_valid = 1'b0;
        z       = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full window: last bit drives, then pix_valid must be up exactly one clock later.
    task automatic full_window(input string tag, input int n_ones, input bit alt,
                               input bit gaps, input int start_at);
        int exp;
        exp_q.push_back(model_pix(alt ? WIN / 2 : n_ones));
        drive_bits(0, WIN - 1, n_ones, alt, gaps, start_at);
        check({tag, "_early"}, pix_valid, 0);
        drive_bits(WIN - 1, WIN, n_ones, alt, 1'b0, -1);
        check({tag, "_valid"}, pix_valid, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_pix"}, pix, exp);
        end
    endtask

    task automatic handshake(input string tag, input bit with_start);
        pix_ready = 1'b1;
        start     = with_start;
        step();
        pix_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_valid_drop"}, pix_valid, 0);
        check({tag, "_busy"}, busy, with_start);
    endtask

    initial begin
        logic [PIX_W-1:0] held;
        rst = 1'b1; start = 1'b0; z = 1'b0; z_valid = 1'b0; abort = 1'b0; pix_ready = 1'b0;
        step(); step();
        check("rst_pix", pix, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Stream data without start must be ignored in IDLE.
        drive_bits(0, 20, 20, 1'b0, 1'b0, -1);
        check("idle_ignore_busy", busy, 0);

        pulse_start();
        check("start_busy", busy, 1);
        full_window("all_ones", WIN, 1'b0, 1'b0, -1);
        handshake("hs_ones", 1'b0);

        pulse_start();
        full_window("all_zeros", 0, 1'b0, 1'b0, -1);
        handshake("hs_zeros", 1'b0);

        pulse_start();
        full_window("alternate", 0, 1'b1, 1'b0, -1);
        handshake("hs_alt", 1'b0);

        pulse_start();
        full_window("stalled", 64, 1'b0, 1'b1, -1);
        handshake("hs_stall", 1'b0);

        // Backpressure with a stray start during HOLD, then a back-to-back window.
        pulse_start();
        full_window("bp", 200, 1'b0, 1'b0, 37);
        held = pix;
        for (int c = 0; c < 10; c++) begin
            start = (c == 4);
            step();
            start = 1'b0;
            check("bp_hold_pix", pix, held);
            check("bp_hold_valid", pix_valid, 1);
        end
        handshake("hs_b2b", 1'b1);
        full_window("b2b", 192, 1'b0, 1'b0, 50);
        handshake("hs_b2b2", 1'b0);

        // Abort mid-window: no result, and the next window starts from zero.
        pulse_start();
        drive_bits(0, 100, 100, 1'b0, 1'b0, -1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", pix_valid, 0);
        pulse_start();
        full_window("after_abort", 32, 1'b0, 1'b0, -1);
        handshake("hs_abort", 1'b0);

        // Abort during HOLD discards the pending pixel.
        pulse_start();
        full_window("hold_abort", 10, 1'b0, 1'b0, -1);
        abort = 1'b1; pix_ready = 1'b1;
        step();
        abort = 1'b0; pix_ready = 1'b0;
        check("hold_abort_valid", pix_valid, 0);
        check("hold_abort_busy", busy, 0);

        // Async reset mid-window takes effect without a clock edge.
        pulse_start();
        drive_bits(0, 50, 50, 1'b0, 1'b0, -1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_valid", pix_valid, 0);
        check("arst_pix", pix, 0);
        step();
        rst = 1'b0;
        step();
        pulse_start();
        full_window("post_rst", 255, 1'b0, 1'b0, -1);
        handshake("hs_post_rst", 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stochastic_to_binary.md
Name: stochastic_to_binary

Overview:
- Downstream stage of the stochastic edge-detection datapath.
- Consumes the single-bit output stream z of the stochastic edge kernel and counts its ones over a fixed window of 2^LEN_LOG2 qualified bits.
- Converts the count to a PIX_W-bit binary edge-magnitude pixel and offers it on a valid/ready output for the image write-back logic.

Parameters:
LEN_LOG2, 8, log2 of stream length per pixel (window = 256 bits); must be >= PIX_W
PIX_W, 8, output pixel width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: begin a new pixel window (accepted in IDLE only)
z  input  1  stochastic bit from the edge kernel
z_valid  input  1  z is qualified this cycle (upstream may stall)
abort  input  1  synchronous discard of the current window
pix  output  PIX_W  converted pixel value
pix_valid  output  1  pix holds a valid result
pix_ready  input  1  downstream accepts pix
busy  output  1  high in ACCUM or HOLD

Behaviour:
- Reset (async, rst=1): state=IDLE; ones_cnt=0, bit_cnt=0, pix=0, pix_valid=0, busy=0. All outputs are registered.
- Counters:
  - bit_cnt is LEN_LOG2 bits wide.
  - ones_cnt is LEN_LOG2+1 bits wide so it can hold a full count of 2^LEN_LOG2.
- IDLE:
  - start=1 -> ACCUM next cycle, with ones_cnt and bit_cnt cleared.
  - z and z_valid are ignored.
- ACCUM:
  - Each cycle with z_valid=1: ones_cnt += z and bit_cnt += 1.
  - Cycles with z_valid=0 change nothing.
  - When z_valid=1 and bit_cnt = 2^LEN_LOG2-1, that bit is included and the state goes to HOLD.
  - On that same edge pix is loaded and pix_valid=1. Latency from the last qualified bit to pix_valid is one clock.
  - start is ignored while in ACCUM.
- Conversion: pix = final ones_cnt >> (LEN_LOG2-PIX_W), saturated to 2^PIX_W-1. A full count of 2^LEN_LOG2 ones yields all-ones.
- HOLD:
  - pix and pix_valid are held stable until pix_ready=1.
  - On the handshake edge: if start=1 in the same cycle -> ACCUM with counters cleared (back-to-back pixels, no idle cycle), pix_valid=0. Otherwise -> IDLE, pix_valid=0.
  - pix keeps its last value after the handshake.
  - start without pix_ready is ignored. z/z_valid are ignored in HOLD.
- abort=1 in ACCUM or HOLD -> IDLE next cycle, pix_valid=0, counters cleared; no result is produced. abort has priority over start, z_valid and the handshake. abort in IDLE has no effect.
- busy=1 exactly while state is ACCUM or HOLD.
- rst asserted mid-window or during HOLD returns to reset values immediately. The next window needs a fresh start.

Test Plan:
- All-ones window: start; 256 cycles z=1, z_valid=1 -> pix_valid rises one cycle after the 256th bit, pix=255 (saturated from 256).
- All-zeros, then alternating: window of z=0 -> pix=0; window of 1,0,1,0... -> pix=128; each handshaken with pix_ready=1.
- Stalled input: 256 valid bits with 64 ones, interleaved with random z_valid=0 gaps carrying z=1 -> pix=64; bit_cnt frozen during gaps.
- Backpressure: pix_ready=0 for 10 cycles after pix_valid -> pix and pix_valid stable. pix_ready=1 with start=1 -> next cycle ACCUM, busy=1, pix_valid=0; second window of 192 ones -> pix=192.
- Abort/reset: abort after 100 bits -> IDLE, no pix_valid; new window of 32 ones -> pix=32 (no carry-over). Async rst mid-ACCUM -> pix_valid=0, busy=0 immediately.
- Ignored start: start pulses during ACCUM and during HOLD (pix_ready=0) -> no restart, counts unaffected, result unchanged.
